// File: rtl/panel_layout_pkg.sv
// Shared widths, default panel geometry, config FSM states and a split helper
// used to compute reset-time split columns.
package panel_layout_pkg;

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned ACC_W = 18;

    localparam int unsigned DEF_OUTER_L = 220;
    localparam int unsigned DEF_OUTER_R = 1060;
    localparam int unsigned DEF_OUTER_T = 210;
    localparam int unsigned DEF_OUTER_B = 510;
    localparam int unsigned DEF_W_A     = 19;
    localparam int unsigned DEF_W_B     = 45;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC1 = 2'd1,
        ST_CALC2 = 2'd2,
        ST_PEND  = 2'd3
    } cfg_state_e;

    // Weighted split (a*wa + b*wb) >> 6 in ACC_W bits, truncated to a column.
    function automatic logic [X_W-1:0] split_fn(input int unsigned a, input int unsigned b,
                                                input int unsigned wa, input int unsigned wb);
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(a * wa + b * wb);
        return X_W'(acc >> 6);
    endfunction

endpackage

// File: rtl/panel_region_scheduler_split_calc.sv
// Combinational weighted split column; shared by both calc states via operand swap.
module split_calc
    import panel_layout_pkg::*;
#(
    parameter int unsigned WA = DEF_W_A,
    parameter int unsigned WB = DEF_W_B
) (
    input  logic [X_W-1:0] a,
    input  logic [X_W-1:0] b,
    output logic [X_W-1:0] sum_c
);

    logic [ACC_W-1:0] acc;

    always_comb begin
        acc   = ACC_W'(a) * ACC_W'(WA) + ACC_W'(b) * ACC_W'(WB);
        sum_c = X_W'(acc >> 6);
    end

endmodule

// File: rtl/panel_region_scheduler.sv
// Three-column panel scheduler: validated config, multi-cycle split calculation,
// frame-boundary commit and a 2-stage pixel region decode producing renderer enables.
module panel_region_scheduler
    import panel_layout_pkg::*;
#(
    parameter int unsigned OUTER_L = DEF_OUTER_L,
    parameter int unsigned OUTER_R = DEF_OUTER_R,
    parameter int unsigned OUTER_T = DEF_OUTER_T,
    parameter int unsigned OUTER_B = DEF_OUTER_B,
    parameter int unsigned W_A     = DEF_W_A,
    parameter int unsigned W_B     = DEF_W_B
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           frame_start,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [X_W-1:0] cfg_left,
    input  logic [X_W-1:0] cfg_right,
    input  logic [Y_W-1:0] cfg_top,
    input  logic [Y_W-1:0] cfg_bottom,
    output logic           cfg_err,
    output logic           cfg_pending,
    output logic [2:0]     en,
    output logic [X_W-1:0] x_d,
    output logic [Y_W-1:0] y_d,
    output logic [X_W-1:0] split1,
    output logic [X_W-1:0] split2
);

    localparam logic [X_W-1:0] OL  = X_W'(OUTER_L);
    localparam logic [X_W-1:0] OR  = X_W'(OUTER_R);
    localparam logic [Y_W-1:0] OT  = Y_W'(OUTER_T);
    localparam logic [Y_W-1:0] OB  = Y_W'(OUTER_B);
    localparam logic [X_W-1:0] RS1 = split_fn(OUTER_R, OUTER_L, W_A, W_B);
    localparam logic [X_W-1:0] RS2 = split_fn(OUTER_R, OUTER_L, W_B, W_A);

    cfg_state_e state_q, state_d;

    logic [X_W-1:0] left_q, left_d, right_q, right_d, split1_q, split1_d, split2_q, split2_d;
    logic [Y_W-1:0] top_q, top_d, bottom_q, bottom_d;
    logic [X_W-1:0] sh_left_q, sh_left_d, sh_right_q, sh_right_d;
    logic [X_W-1:0] sh_split1_q, sh_split1_d, sh_split2_q, sh_split2_d;
    logic [Y_W-1:0] sh_top_q, sh_top_d, sh_bottom_q, sh_bottom_d;
    logic           cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d, cfg_pending_q, cfg_pending_d;

    logic [X_W-1:0] x1_q, x1_d, xd_q, xd_d;
    logic [Y_W-1:0] y1_q, y1_d, yd_q, yd_d;
    logic           out1_q, out1_d, rows1_q, rows1_d;
    logic           c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [2:0]     en_q, en_d;

    logic           hs, bad;
    logic [X_W-1:0] calc_a, calc_b, calc_sum;

    assign hs  = cfg_valid & cfg_ready_q;
    assign bad = (cfg_left >= cfg_right) || (cfg_top >= cfg_bottom);

    // One shared multiplier path; CALC2 swaps operands to get the mirrored weight.
    split_calc #(.WA(W_A), .WB(W_B)) u_split_calc (
        .a     (calc_a),
        .b     (calc_b),
        .sum_c (calc_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            left_q        <= OL;
            right_q       <= OR;
            top_q         <= OT;
            bottom_q      <= OB;
            split1_q      <= RS1;
            split2_q      <= RS2;
            sh_left_q     <= OL;
            sh_right_q    <= OR;
            sh_top_q      <= OT;
            sh_bottom_q   <= OB;
            sh_split1_q   <= RS1;
            sh_split2_q   <= RS2;
            cfg_ready_q   <= 1'b1;
            cfg_err_q     <= 1'b0;
            cfg_pending_q <= 1'b0;
            x1_q          <= '0;
            y1_q          <= '0;
            out1_q        <= 1'b0;
            rows1_q       <= 1'b0;
            c1_q          <= 1'b0;
            c2_q          <= 1'b0;
            c3_q          <= 1'b0;
            en_q          <= 3'b000;
            xd_q          <= '0;
            yd_q          <= '0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            right_q       <= right_d;
            top_q         <= top_d;
            bottom_q      <= bottom_d;
            split1_q      <= split1_d;
            split2_q      <= split2_d;
            sh_left_q     <= sh_left_d;
            sh_right_q    <= sh_right_d;
            sh_top_q      <= sh_top_d;
            sh_bottom_q   <= sh_bottom_d;
            sh_split1_q   <= sh_split1_d;
            sh_split2_q   <= sh_split2_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            cfg_pending_q <= cfg_pending_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            out1_q        <= out1_d;
            rows1_q       <= rows1_d;
            c1_q          <= c1_d;
            c2_q          <= c2_d;
            c3_q          <= c3_d;
            en_q          <= en_d;
            xd_q          <= xd_d;
            yd_q          <= yd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs && !bad) state_d = ST_CALC1;
            ST_CALC1: state_d = ST_CALC2;
            ST_CALC2: state_d = ST_PEND;
            ST_PEND:  if (frame_start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        left_d        = left_q;
        right_d       = right_q;
        top_d         = top_q;
        bottom_d      = bottom_q;
        split1_d      = split1_q;
        split2_d      = split2_q;
        sh_left_d     = sh_left_q;
        sh_right_d    = sh_right_q;
        sh_top_d      = sh_top_q;
        sh_bottom_d   = sh_bottom_q;
        sh_split1_d   = sh_split1_q;
        sh_split2_d   = sh_split2_q;
        cfg_err_d     = 1'b0;
        cfg_ready_d   = (state_d == ST_IDLE);
        cfg_pending_d = (state_d == ST_PEND);
        calc_a        = (state_q == ST_CALC2) ? sh_left_q  : sh_right_q;
        calc_b        = (state_q == ST_CALC2) ? sh_right_q : sh_left_q;
        case (state_q)
            ST_IDLE: begin
                if (hs && bad) begin
                    cfg_err_d = 1'b1;
                end else if (hs) begin
                    sh_left_d   = cfg_left;
                    sh_right_d  = cfg_right;
                    sh_top_d    = cfg_top;
                    sh_bottom_d = cfg_bottom;
                end
            end
            ST_CALC1: sh_split1_d = calc_sum;
            ST_CALC2: sh_split2_d = calc_sum;
            ST_PEND: begin
                if (frame_start) begin
                    left_d   = sh_left_q;
                    right_d  = sh_right_q;
                    top_d    = sh_top_q;
                    bottom_d = sh_bottom_q;
                    split1_d = sh_split1_q;
                    split2_d = sh_split2_q;
                end
            end
            default: ;
        endcase
    end

    // Stage 1 compares against the active layout; stage 2 resolves priority into en.
    always_comb begin
        x1_d    = x;
        y1_d    = y;
        out1_d  = (x < OL) || (x > OR) || (y < OT) || (y > OB);
        rows1_d = (y > top_q) && (y < bottom_q);
        c1_d    = (x > left_q) && (x < split1_q);
        c2_d    = (x > split1_q) && (x < split2_q);
        c3_d    = (x >= split2_q) && (x < right_q);
        xd_d    = x1_q;
        yd_d    = y1_q;
        en_d    = 3'b000;
        if (out1_q)               en_d = 3'b111;
        else if (rows1_q && c1_q) en_d = 3'b001;
        else if (rows1_q && c2_q) en_d = 3'b010;
        else if (rows1_q && c3_q) en_d = 3'b100;
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign cfg_pending = cfg_pending_q;
    assign en          = en_q;
    assign x_d         = xd_q;
    assign y_d         = yd_q;
    assign split1      = split1_q;
    assign split2      = split2_q;

endmodule

// File: tb/tb_panel_region_scheduler.sv
// Directed bench for panel_region_scheduler: pixel expectations go through a
// scoreboard queue and are compared when the 2-stage pipeline delivers them.
module tb_panel_region_scheduler;

    typedef struct packed {
        logic [2:0]  en;
        logic [10:0] x;
        logic [9:0]  y;
    } pix_t;

    logic        clk, rst;
    logic [10:0] x, cfg_left, cfg_right, x_d, split1, split2;
    logic [9:0]  y, cfg_top, cfg_bottom, y_d;
    logic        frame_start, cfg_valid, cfg_ready, cfg_err, cfg_pending;
    logic [2:0]  en;

    int   checks   = 0;
    int   failures = 0;
    pix_t sb[$];

    panel_region_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_left    (cfg_left),
        .cfg_right   (cfg_right),
        .cfg_top     (cfg_top),
        .cfg_bottom  (cfg_bottom),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .en          (en),
        .x_d         (x_d),
        .y_d         (y_d),
        .split1      (split1),
        .split2      (split2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel, then compare once it has crossed both pipeline stages.
    task automatic pix(input logic [10:0] px, input logic [9:0] py, input logic [2:0] exp_en);
        pix_t e;
        x = px;
        y = py;
        e.en = exp_en;
        e.x  = px;
        e.y  = py;
        sb.push_back(e);
        step();
        step();
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("en x=%0d y=%0d", e.x, e.y), 32'(en), 32'(e.en));
            chk("x_d", 32'(x_d), 32'(e.x));
            chk("y_d", 32'(y_d), 32'(e.y));
        end
    endtask

    task automatic set_cfg(input int l, input int r, input int t, input int b);
        cfg_left   = 11'(l);
        cfg_right  = 11'(r);
        cfg_top    = 10'(t);
        cfg_bottom = 10'(b);
    endtask

    initial begin
        rst = 1'b0; x = '0; y = '0; frame_start = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_x_d", 32'(x_d), 32'd0);
        chk("rst_y_d", 32'(y_d), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_split1", 32'(split1), 32'd469);
        chk("rst_split2", 32'(split2), 32'd810);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();

        // Default layout decode
        pix(300, 300, 3'b001);
        pix(600, 300, 3'b010);
        pix(900, 300, 3'b100);
        pix(469, 300, 3'b000);
        pix(810, 300, 3'b100);
        pix(100, 300, 3'b111);
        pix(100, 50,  3'b111);
        pix(300, 100, 3'b111);
        pix(1061, 300, 3'b111);

        // Accept 300/1000/250/450; frame_start on the edge entering PEND is ignored
        set_cfg(300, 1000, 250, 450);
        cfg_valid = 1'b1;
        chk("ready_idle", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        chk("ready_calc1", 32'(cfg_ready), 32'd0);
        chk("pend_calc1", 32'(cfg_pending), 32'd0);
        step();
        chk("pend_calc2", 32'(cfg_pending), 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("pend_set", 32'(cfg_pending), 32'd1);
        chk("no_early_commit", 32'(split1), 32'd469);

        // Held offer while pending must not be accepted
        set_cfg(10, 20, 5, 8);
        cfg_valid = 1'b1;
        step();
        chk("ready_pend", 32'(cfg_ready), 32'd0);
        pix(480, 300, 3'b010);
        chk("ready_pend2", 32'(cfg_ready), 32'd0);
        chk("still_pend", 32'(cfg_pending), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cfg_valid = 1'b0;
        chk("commit_split1", 32'(split1), 32'd507);
        chk("commit_split2", 32'(split2), 32'd792);
        chk("commit_pend", 32'(cfg_pending), 32'd0);
        chk("commit_ready", 32'(cfg_ready), 32'd1);
        step();
        chk("no_second_accept", 32'(cfg_ready), 32'd1);

        // New layout decode
        pix(480, 300, 3'b001);
        pix(300, 300, 3'b000);
        pix(600, 300, 3'b010);
        pix(900, 300, 3'b100);
        pix(1010, 300, 3'b000);
        pix(480, 240, 3'b000);

        // Rejected config
        set_cfg(500, 400, 250, 450);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_ready", 32'(cfg_ready), 32'd1);
        chk("err_pend", 32'(cfg_pending), 32'd0);
        step();
        chk("err_clear", 32'(cfg_err), 32'd0);
        chk("err_split1", 32'(split1), 32'd507);
        chk("err_split2", 32'(split2), 32'd792);

        // Reset during CALC2 discards the shadow set
        set_cfg(400, 900, 220, 500);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        chk("mid_rst_pend", 32'(cfg_pending), 32'd0);
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_x_d", 32'(x_d), 32'd0);
        chk("mid_rst_split1", 32'(split1), 32'd469);
        chk("mid_rst_split2", 32'(split2), 32'd810);
        @(negedge clk) rst = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("post_rst_pend", 32'(cfg_pending), 32'd0);
        chk("post_rst_split1", 32'(split1), 32'd469);
        chk("post_rst_split2", 32'(split2), 32'd810);
        pix(300, 300, 3'b001);
        pix(600, 300, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_region_scheduler.md
# panel_region_scheduler

Schedules the three-column panel layout of the display pipeline. It accepts new panel geometry through a valid/ready configuration port and computes the two column split points with a multi-cycle FSM. It commits the new layout only at a frame boundary. Per pixel it issues registered one-hot (or all-ones background) clock enables to the three panel renderers, so no gated clocks are needed downstream.

## Interface
Parameters:
- OUTER_L, 220: outer window left (11-bit)
- OUTER_R, 1060: outer window right
- OUTER_T, 210: outer window top (10-bit)
- OUTER_B, 510: outer window bottom
- W_A, 19: narrow split weight (3/10 of 64)
- W_B, 45: wide split weight (7/10 of 64); W_A+W_B must equal 64

Ports (one clock `clk`; `rst` asynchronous, active-high):
- clk  in  1  pixel clock
- rst  in  1  async active-high reset
- x  in  11  current pixel column
- y  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accept
- cfg_left, cfg_right  in  11  panel horizontal bounds
- cfg_top, cfg_bottom  in  10  panel vertical bounds
- cfg_err  out  1  one-cycle pulse: rejected config
- cfg_pending  out  1  validated config waiting for frame_start
- en  out  3  renderer clock enables, bit i = panel i+1
- x_d  out  11  x delayed to align with en
- y_d  out  10  y delayed to align with en
- split1, split2  out  11  active split columns (debug/overlay)

## Operation
- Active layout registers: left, right, top, bottom, split1, split2. Shadow registers hold the pending set.
- Split arithmetic is 18-bit unsigned, truncated to 11 bits:
  - split1 = (right*W_A + left*W_B) >> 6
  - split2 = (right*W_B + left*W_A) >> 6
- Config FSM states: IDLE, CALC1, CALC2, PEND.
  - IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) with cfg_left>=cfg_right or cfg_top>=cfg_bottom pulses cfg_err next cycle, discards the data and stays in IDLE. A valid handshake latches the shadow bounds and moves to CALC1.
  - CALC1: computes shadow split1, then CALC2.
  - CALC2: computes shadow split2, then PEND.
  - PEND: cfg_pending=1, cfg_ready=0. On sampled frame_start, all six active registers load from shadow and the FSM returns to IDLE.
  - frame_start outside PEND has no effect.
- Region decode, priority top to bottom:
  - x<OUTER_L, x>OUTER_R, y<OUTER_T or y>OUTER_B: en=3'b111
  - y>top, y<bottom, x>left, x<split1: en=3'b001
  - same rows, x>split1, x<split2: en=3'b010
  - same rows, x>=split2, x<right: en=3'b100
  - otherwise en=3'b000
- The decode uses active registers only. A commit never changes the layout inside a frame.

## Timing
- Reset values:
  - FSM=IDLE, cfg_ready=1, cfg_err=0, cfg_pending=0, en=3'b000, x_d=0, y_d=0
  - active left/right/top/bottom = OUTER_L/R/T/B
  - split1=469, split2=810
- Pixel path is a 2-stage pipeline:
  - stage 1 registers x, y and the compare results
  - stage 2 registers en
  - en, x_d and y_d correspond to the x/y sampled two edges earlier
- Config latency: handshake edge to PEND is 3 cycles.
- Commit: the first pixel sampled after the commit edge uses the new layout. Its en appears 2 cycles later.
- frame_start in the cycle the FSM enters PEND is not seen; only frame_start sampled while in PEND commits.
- rst mid-calculation discards the shadow set and restores the defaults.

## Structure
- Package panel_layout_pkg holds:
  - OUTER_* defaults, W_A, W_B
  - widths X_W=11, Y_W=10, ACC_W=18
  - the FSM state enum
- Sub-module split_calc: combinational weighted sum and shift. It is instantiated once and shared by CALC1 and CALC2 through operand swap.

## Test plan
- Reset, then x=300, y=300: en=001 two cycles later; x=600: en=010; x=900: en=100; split1=469, split2=810.
- x=469, y=300 gives en=000; x=810, y=300 gives en=100; x=100 at any y gives en=111.
- Config 300/1000/250/450: cfg_pending=1 3 cycles after the handshake.
  - Before frame_start, x=480 still gives en=010.
  - After frame_start, split1=(19000+13500)>>6=507 and split2=(45000+5700)>>6=792, so x=480 gives en=001.
- Config left=500, right=400: cfg_err pulses one cycle, cfg_ready stays 1, layout unchanged.
- cfg_valid held high in PEND: cfg_ready=0 and no second accept until after commit.
- rst asserted in CALC2: all outputs return to their reset values immediately and no commit occurs on the next frame_start.
